// File: rtl/logit_frame_packer.sv
// Packs one signed class score per beat into a parallel frame of NUM_CLASSES scores.
// A fill buffer plus an output register lets the next frame fill while one waits.
module logit_frame_packer #(
   parameter int DATA_W      = 12,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_W       = 4,
   parameter int CNT_W       = 16
) (
   input  logic                          gclk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_CLASSES*DATA_W-1:0] out_data,
   output logic                          frame_err,
   output logic [CNT_W-1:0]              frame_cnt
);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [DATA_W-1:0]               fill_buf_q [NUM_CLASSES];
   logic [DATA_W-1:0]               fill_buf_d [NUM_CLASSES];
   logic [NUM_CLASSES*DATA_W-1:0]   out_data_q, out_data_d;
   logic                            out_valid_q, out_valid_d;
   logic                            in_ready_q, in_ready_d;
   logic                            frame_err_q, frame_err_d;
   logic [CNT_W-1:0]                frame_cnt_q, frame_cnt_d;

   logic                            accept_s;
   logic                            take_s;
   logic                            out_free_s;
   logic [NUM_CLASSES*DATA_W-1:0]   frame_s;

   assign accept_s   = in_valid && in_ready_q;
   assign take_s     = out_valid_q && out_ready;
   assign out_free_s = !out_valid_q || out_ready;

   // Assemble the candidate frame; while filling, the final class comes straight from the input beat.
   always_comb begin
      frame_s = '0;
      for (int k = 0; k < NUM_CLASSES - 1; k++) begin
         frame_s[k*DATA_W +: DATA_W] = fill_buf_q[k];
      end
      frame_s[(NUM_CLASSES-1)*DATA_W +: DATA_W] =
         (state_q == ST_HOLD) ? fill_buf_q[NUM_CLASSES-1] : in_data;
   end

   // Next-state logic for the fill/hold controller and all registered outputs.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      fill_buf_d  = fill_buf_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !take_s;
      frame_err_d = 1'b0;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         ST_FILL: begin
            if (accept_s) begin
               if (idx_q == LAST_IDX) begin
                  // Frame is complete by position; a missing in_last is flagged but the frame still ships.
                  frame_err_d = !in_last;
                  if (out_free_s) begin
                     out_data_d  = frame_s;
                     out_valid_d = 1'b1;
                     frame_cnt_d = frame_cnt_q + CNT_W'(1);
                     idx_d       = '0;
                  end else begin
                     fill_buf_d[NUM_CLASSES-1] = in_data;
                     state_d                   = ST_HOLD;
                  end
               end else if (in_last) begin
                  frame_err_d = 1'b1;
                  idx_d       = '0;
               end else begin
                  fill_buf_d[idx_q] = in_data;
                  idx_d             = idx_q + IDX_W'(1);
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_HOLD: begin
            if (out_free_s) begin
               out_data_d  = frame_s;
               out_valid_d = 1'b1;
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               idx_d       = '0;
               state_d     = ST_FILL;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_FILL;
            idx_d   = '0;
         end
      endcase

      in_ready_d = (state_d == ST_FILL);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
         for (int k = 0; k < NUM_CLASSES; k++) begin
            fill_buf_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
         for (int k = 0; k < NUM_CLASSES; k++) begin
            fill_buf_q[k] <= fill_buf_d[k];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign frame_err = frame_err_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_logit_frame_packer.sv
// Bench for logit_frame_packer: directed scenarios plus random traffic against a queue-based frame model.
module tb_logit_frame_packer;

   localparam int DW = 12;
   localparam int NC = 10;
   localparam int IW = 4;
   localparam int CW = 4;

   logic                 gclk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [DW-1:0]        in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [NC*DW-1:0]     out_data;
   logic                 frame_err;
   logic [CW-1:0]        frame_cnt;

   always #5 gclk = ~gclk;

   logit_frame_packer #(
      .DATA_W(DW), .NUM_CLASSES(NC), .IDX_W(IW), .CNT_W(CW)
   ) dut (
      .gclk(gclk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   // Reference model: scores gathered so far, a frame waiting for the output, and the visible frame.
   logic [DW-1:0] m_beats [$];
   logic [DW-1:0] m_pend  [$];
   logic [DW-1:0] m_out   [NC];
   bit            m_vld;
   bit            m_err;
   int            m_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic void model_clear();
      m_beats.delete();
      m_pend.delete();
      m_vld = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
      for (int k = 0; k < NC; k++) m_out[k] = '0;
   endfunction

   function automatic void deliver(input logic [DW-1:0] q [$]);
      for (int k = 0; k < NC; k++) m_out[k] = q[k];
      m_vld = 1'b1;
      m_cnt = (m_cnt + 1) % (1 << CW);
   endfunction

   function automatic void model_edge(input bit iv, input logic [DW-1:0] d, input bit last, input bit ordy);
      bit free;
      free  = !m_vld || ordy;
      m_err = 1'b0;
      if (m_vld && ordy) m_vld = 1'b0;
      if (m_pend.size() != 0) begin
         if (free) begin
            deliver(m_pend);
            m_pend.delete();
         end
      end else if (iv) begin
         m_beats.push_back(d);
         if (m_beats.size() == NC) begin
            m_err = !last;
            if (free) deliver(m_beats);
            else      m_pend = m_beats;
            m_beats.delete();
         end else if (last) begin
            m_err = 1'b1;
            m_beats.delete();
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [NC*DW-1:0] exp_vec;
      chk("in_ready",  128'(in_ready),  128'(m_pend.size() == 0));
      chk("out_valid", 128'(out_valid), 128'(m_vld));
      chk("frame_err", 128'(frame_err), 128'(m_err));
      chk("frame_cnt", 128'(frame_cnt), 128'(m_cnt));
      if (m_vld) begin
         for (int k = 0; k < NC; k++) exp_vec[k*DW +: DW] = m_out[k];
         chk("out_data", 128'(out_data), 128'(exp_vec));
      end
   endtask

   task automatic step(input bit iv, input logic [DW-1:0] d, input bit last, input bit ordy);
      @(negedge gclk);
      in_valid  = iv;
      in_data   = d;
      in_last   = last;
      out_ready = ordy;
      @(posedge gclk);
      model_edge(iv, d, last, ordy);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge gclk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      model_clear();
      #1;
      check_all();
      chk("rst_out_data", 128'(out_data), 128'(0));
      @(posedge gclk);
      #1;
      check_all();
      @(negedge gclk);
      rst_n = 1'b1;
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [31:0] r;
      r = $urandom;
      return r[DW-1:0];
   endfunction

   initial begin
      int            t1 [NC];
      logic [DW-1:0] keep;
      bit            iv;
      bit            last;
      bit            ordy;
      int            r;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      do_reset();

      // T1: fixed scores including both extremes
      t1 = '{-5, 3, 100, 7, -2048, 2047, 0, 1, -1, 9};
      for (int i = 0; i < NC; i++) step(1'b1, DW'(t1[i]), i == NC - 1, 1'b1);
      chk("t1_class5", 128'(out_data[5*DW +: DW]), 128'(12'h7FF));
      chk("t1_class4", 128'(out_data[4*DW +: DW]), 128'(12'h800));
      chk("t1_class0", 128'(out_data[0 +: DW]),    128'(12'hFFB));
      chk("t1_cnt",    128'(frame_cnt),            128'(1));
      step(1'b0, '0, 1'b0, 1'b1);
      chk("t1_drop",   128'(out_valid),            128'(0));

      // T2: three frames back to back
      for (int i = 0; i < 3 * NC; i++) step(1'b1, rnd(), (i % NC) == NC - 1, 1'b1);
      chk("t2_cnt", 128'(frame_cnt), 128'(4));
      step(1'b0, '0, 1'b0, 1'b1);

      // T3: consumer stalled across two frames
      for (int i = 0; i < 2 * NC; i++) step(1'b1, rnd(), (i % NC) == NC - 1, 1'b0);
      chk("t3_in_ready_low", 128'(in_ready), 128'(0));
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("t3_in_ready_high", 128'(in_ready), 128'(1));
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);

      // T4: early last on the fifth beat
      for (int i = 0; i < 5; i++) step(1'b1, rnd(), i == 4, 1'b1);
      chk("t4_err", 128'(frame_err), 128'(1));
      chk("t4_no_valid", 128'(out_valid), 128'(0));
      for (int i = 0; i < NC; i++) step(1'b1, rnd(), i == NC - 1, 1'b1);

      // T5: missing last, then the next beat starts a new frame
      for (int i = 0; i < NC; i++) step(1'b1, rnd(), 1'b0, 1'b1);
      chk("t5_err", 128'(frame_err), 128'(1));
      keep = rnd();
      step(1'b1, keep, 1'b0, 1'b1);
      for (int i = 1; i < NC; i++) step(1'b1, rnd(), i == NC - 1, 1'b1);
      chk("t5_class0", 128'(out_data[0 +: DW]), 128'(keep));

      // T6: reset in the middle of a frame
      for (int i = 0; i < 7; i++) step(1'b1, rnd(), 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < NC; i++) step(1'b1, rnd(), i == NC - 1, 1'b1);
      chk("t6_cnt", 128'(frame_cnt), 128'(1));

      // Random traffic with stalls, framing errors and counter wrap
      for (int n = 0; n < 600; n++) begin
         iv   = ($urandom_range(0, 3) != 0);
         r    = $urandom_range(0, 29);
         last = (m_beats.size() == NC - 1) ? (r != 0) : (r == 0);
         ordy = ($urandom_range(0, 9) < 7);
         step(iv, rnd(), last, ordy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
